// File: rtl/mem_bus_arbiter.sv
// Shares one fixed-latency memory bus between the instruction-fetch port (F) and the
// load/store port (D). Arbitration is round-robin, or D-first when DATA_PRIORITY is set.
module mem_bus_arbiter #(
    parameter int unsigned MEM_LATENCY   = 1,
    parameter int unsigned DATA_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_data,
    input  logic [2:0]  d_wr_length,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_read_data,
    output logic [2:0]  bus_write_length,
    output logic        bus_wr_enable,
    output logic        bus_valid,
    output logic        busy
);

    localparam int unsigned      CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic             PRI_D    = (DATA_PRIORITY != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner_d;
    logic             r_last_d;
    logic             r_store;

    logic             w_any_req;
    logic             w_grant_d;

    // D wins when alone, when it has fixed priority, or when F was granted last
    assign w_any_req = f_req | d_req;
    assign w_grant_d = d_req & (~f_req | PRI_D | ~r_last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_owner_d        <= 1'b0;
            r_last_d         <= 1'b1;
            r_store          <= 1'b0;
            f_ack            <= 1'b0;
            f_rdata          <= '0;
            d_ack            <= 1'b0;
            d_rdata          <= '0;
            bus_address      <= '0;
            bus_wr_data      <= '0;
            bus_write_length <= '0;
            bus_wr_enable    <= 1'b0;
            bus_valid        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state       <= S_ACCESS;
                        r_cnt         <= CNT_LOAD;
                        r_owner_d     <= w_grant_d;
                        r_last_d      <= w_grant_d;
                        r_store       <= w_grant_d & d_wr_en;
                        bus_address   <= w_grant_d ? d_addr : f_addr;
                        if (w_grant_d) begin
                            bus_wr_data      <= d_wr_data;
                            bus_write_length <= d_wr_length;
                        end
                        bus_wr_enable <= w_grant_d & d_wr_en;
                        bus_valid     <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // write strobe only on the first access cycle
                    bus_wr_enable <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state   <= S_RESP;
                        bus_valid <= 1'b0;
                        if (r_owner_d) begin
                            d_ack <= 1'b1;
                            if (!r_store) begin
                                d_rdata <= bus_read_data;
                            end
                        end else begin
                            f_ack   <= 1'b1;
                            f_rdata <= bus_read_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state       <= S_IDLE;
                    bus_valid     <= 1'b0;
                    bus_wr_enable <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (L=1 RR, L=3 RR, L=3 D-priority), a vector
// table, hand-written corner sequences and a random run against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req            [NI];
    logic [31:0] f_addr           [NI];
    logic        f_ack            [NI];
    logic [31:0] f_rdata          [NI];
    logic        d_req            [NI];
    logic [31:0] d_addr           [NI];
    logic        d_wr_en          [NI];
    logic [31:0] d_wr_data        [NI];
    logic [2:0]  d_wr_length      [NI];
    logic        d_ack            [NI];
    logic [31:0] d_rdata          [NI];
    logic [31:0] bus_address      [NI];
    logic [31:0] bus_wr_data      [NI];
    logic [31:0] bus_read_data    [NI];
    logic [2:0]  bus_write_length [NI];
    logic        bus_wr_enable    [NI];
    logic        bus_valid        [NI];
    logic        busy             [NI];

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic bit pri_of(input int g);
        return (g == 2);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_bus_arbiter #(
            .MEM_LATENCY  ((g == 0) ? 1 : 3),
            .DATA_PRIORITY((g == 2) ? 1 : 0)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .f_req           (f_req[g]),
            .f_addr          (f_addr[g]),
            .f_ack           (f_ack[g]),
            .f_rdata         (f_rdata[g]),
            .d_req           (d_req[g]),
            .d_addr          (d_addr[g]),
            .d_wr_en         (d_wr_en[g]),
            .d_wr_data       (d_wr_data[g]),
            .d_wr_length     (d_wr_length[g]),
            .d_ack           (d_ack[g]),
            .d_rdata         (d_rdata[g]),
            .bus_address     (bus_address[g]),
            .bus_wr_data     (bus_wr_data[g]),
            .bus_read_data   (bus_read_data[g]),
            .bus_write_length(bus_write_length[g]),
            .bus_wr_enable   (bus_wr_enable[g]),
            .bus_valid       (bus_valid[g]),
            .busy            (busy[g])
        );
        assign bus_read_data[g] = mem_word(bus_address[g]);
    end

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            f_req[i]       = 1'b0;
            f_addr[i]      = '0;
            d_req[i]       = 1'b0;
            d_addr[i]      = '0;
            d_wr_en[i]     = 1'b0;
            d_wr_data[i]   = '0;
            d_wr_length[i] = '0;
        end
    endtask

    task automatic check_zero(input int g, input string tag);
        chk($sformatf("%s%0d f_ack", tag, g), 32'(f_ack[g]), 32'd0);
        chk($sformatf("%s%0d d_ack", tag, g), 32'(d_ack[g]), 32'd0);
        chk($sformatf("%s%0d f_rdata", tag, g), f_rdata[g], 32'd0);
        chk($sformatf("%s%0d d_rdata", tag, g), d_rdata[g], 32'd0);
        chk($sformatf("%s%0d bus_address", tag, g), bus_address[g], 32'd0);
        chk($sformatf("%s%0d bus_wr_data", tag, g), bus_wr_data[g], 32'd0);
        chk($sformatf("%s%0d bus_len", tag, g), 32'(bus_write_length[g]), 32'd0);
        chk($sformatf("%s%0d bus_wr_enable", tag, g), 32'(bus_wr_enable[g]), 32'd0);
        chk($sformatf("%s%0d bus_valid", tag, g), 32'(bus_valid[g]), 32'd0);
        chk($sformatf("%s%0d busy", tag, g), 32'(busy[g]), 32'd0);
    endtask

    task automatic chk_acks(input int g, input bit ef, input bit ed, input string tag);
        chk({tag, " f_ack"}, 32'(f_ack[g]), 32'(ef));
        chk({tag, " d_ack"}, 32'(d_ack[g]), 32'(ed));
    endtask

    typedef struct {
        int          inst;
        bit          is_d;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [2:0]  len;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic apply_vec(input int idx, input vec_t v);
        int    g;
        int    lat;
        int    nvalid;
        int    nwr;
        string tag;
        g      = v.inst;
        lat    = -1;
        nvalid = 0;
        nwr    = 0;
        tag    = $sformatf("vec%0d", idx);
        if (v.is_d) begin
            d_req[g]       = 1'b1;
            d_addr[g]      = v.addr;
            d_wr_en[g]     = v.wr;
            d_wr_data[g]   = v.wdata;
            d_wr_length[g] = v.len;
        end else begin
            f_req[g]  = 1'b1;
            f_addr[g] = v.addr;
        end
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            step();
            if (bus_valid[g]) begin
                nvalid++;
                chk({tag, " bus_address"}, bus_address[g], v.addr);
            end
            if (bus_wr_enable[g]) begin
                nwr++;
                chk({tag, " bus_wr_data"}, bus_wr_data[g], v.wdata);
                chk({tag, " bus_len"}, 32'(bus_write_length[g]), 32'(v.len));
            end
            chk({tag, " other ack"}, 32'(v.is_d ? f_ack[g] : d_ack[g]), 32'd0);
            if (v.is_d ? d_ack[g] : f_ack[g]) begin
                lat = c;
                f_req[g] = 1'b0;
                d_req[g] = 1'b0;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " rdata"}, v.is_d ? d_rdata[g] : f_rdata[g], v.exp_rdata);
        chk({tag, " valid cycles"}, 32'(nvalid), 32'(lat_of(g)));
        chk({tag, " wr cycles"}, 32'(nwr), 32'(v.wr));
        step();
        chk({tag, " ack pulse width"}, 32'(v.is_d ? d_ack[g] : f_ack[g]), 32'd0);
        chk({tag, " busy after"}, 32'(busy[g]), 32'd0);
        step();
    endtask

    // Transaction-level reference: each grant at interval k0 owns the bus for
    // intervals k0+1..k0+L, acks at k0+L+1, and the arbiter is free again at k0+L+2.
    task automatic run_random(input int g, input int n);
        int          L;
        bit          P;
        int          k;
        int          idle_from;
        int          k0;
        bit          have;
        bit          acc_d;
        bit          acc_wr;
        logic [31:0] acc_addr;
        logic [31:0] acc_wdata;
        logic [2:0]  acc_len;
        logic [31:0] exp_f;
        logic [31:0] exp_d;
        bit          last_d;
        bit          in_acc;
        bit          in_resp;
        bit          dw;
        L = lat_of(g);
        P = pri_of(g);
        idle_all();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        k = 0; idle_from = 0; k0 = 0; have = 1'b0; acc_d = 1'b0; acc_wr = 1'b0;
        acc_addr = '0; acc_wdata = '0; acc_len = '0; exp_f = '0; exp_d = '0; last_d = 1'b1;
        for (int it = 0; it < n; it++) begin
            in_acc  = have && (k >= k0 + 1) && (k <= k0 + L);
            in_resp = have && (k == k0 + L + 1);
            if (in_resp) begin
                if (!acc_d) exp_f = mem_word(acc_addr);
                else if (!acc_wr) exp_d = mem_word(acc_addr);
            end
            chk("rnd bus_valid", 32'(bus_valid[g]), 32'(in_acc));
            chk("rnd bus_wr_enable", 32'(bus_wr_enable[g]), 32'(in_acc && k == k0 + 1 && acc_wr));
            chk("rnd busy", 32'(busy[g]), 32'(in_acc || in_resp));
            chk("rnd f_ack", 32'(f_ack[g]), 32'(in_resp && !acc_d));
            chk("rnd d_ack", 32'(d_ack[g]), 32'(in_resp && acc_d));
            chk("rnd f_rdata", f_rdata[g], exp_f);
            chk("rnd d_rdata", d_rdata[g], exp_d);
            if (in_acc) begin
                chk("rnd bus_address", bus_address[g], acc_addr);
                if (acc_wr) begin
                    chk("rnd bus_wr_data", bus_wr_data[g], acc_wdata);
                    chk("rnd bus_len", 32'(bus_write_length[g]), 32'(acc_len));
                end
            end
            // requesters: drop on ack, otherwise raise at random and hold
            if (in_resp && !acc_d) f_req[g] = 1'b0;
            else if (!f_req[g] && $urandom_range(0, 1) == 0) begin
                f_req[g]  = 1'b1;
                f_addr[g] = $urandom() & 32'hFFFF_FFFC;
            end
            if (in_resp && acc_d) d_req[g] = 1'b0;
            else if (!d_req[g] && $urandom_range(0, 1) == 0) begin
                d_req[g]       = 1'b1;
                d_addr[g]      = $urandom() & 32'hFFFF_FFFC;
                d_wr_en[g]     = 1'($urandom_range(0, 1));
                d_wr_data[g]   = $urandom();
                d_wr_length[g] = 3'($urandom_range(0, 7));
            end
            if (k >= idle_from && (f_req[g] || d_req[g])) begin
                dw        = d_req[g] && (!f_req[g] || P || !last_d);
                have      = 1'b1;
                k0        = k;
                acc_d     = dw;
                acc_wr    = dw && d_wr_en[g];
                acc_addr  = dw ? d_addr[g] : f_addr[g];
                acc_wdata = d_wr_data[g];
                acc_len   = d_wr_length[g];
                last_d    = dw;
                idle_from = k + L + 2;
            end
            step();
            k++;
        end
        idle_all();
    endtask

    vec_t vt[8];

    initial begin
        reset = 1'b0;
        idle_all();
        step();
        step();
        for (int g = 0; g < NI; g++) check_zero(g, "reset");
        reset = 1'b1;
        step();

        vt[0] = '{0, 1'b0, 32'h0000_0010, 1'b0, 32'h0, 3'd0, 2, 32'h0050_0093};
        vt[1] = '{0, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 3'd0, 2, 32'h5A5A_0100};
        vt[2] = '{0, 1'b1, 32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 3'd2, 2, 32'h5A5A_0100};
        vt[3] = '{0, 1'b0, 32'h0000_0204, 1'b0, 32'h0, 3'd0, 2, 32'h5A5A_0204};
        vt[4] = '{0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 3'd0, 2, 32'h5A5A_0000};
        vt[5] = '{0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 3'd7, 2, 32'h5A5A_0000};
        vt[6] = '{1, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 3'd0, 4, 32'h5A5A_0100};
        vt[7] = '{1, 1'b1, 32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 3'd2, 4, 32'h5A5A_0100};
        for (int i = 0; i < 8; i++) apply_vec(i, vt[i]);

        // reset in the middle of a D store on the L=3 instance
        d_req[1] = 1'b1; d_addr[1] = 32'h40; d_wr_en[1] = 1'b1;
        d_wr_data[1] = 32'h1111_2222; d_wr_length[1] = 3'd1;
        step();
        chk("abort wr_enable", 32'(bus_wr_enable[1]), 32'd1);
        step();
        #2;
        reset = 1'b0;
        #1;
        check_zero(1, "abort");
        idle_all();
        step();
        chk("abort no d_ack a", 32'(d_ack[1]), 32'd0);
        step();
        chk("abort no d_ack b", 32'(d_ack[1]), 32'd0);
        reset = 1'b1;
        // first tie after reset goes to F, then D
        f_req[1] = 1'b1; f_addr[1] = 32'h10;
        d_req[1] = 1'b1; d_addr[1] = 32'h204; d_wr_en[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_acks(1, k == 4, k == 9, $sformatf("tie@%0d", k));
            if (f_ack[1]) f_req[1] = 1'b0;
            if (d_ack[1]) d_req[1] = 1'b0;
        end
        chk("tie f_rdata", f_rdata[1], 32'h0050_0093);
        chk("tie d_rdata", d_rdata[1], 32'h5A5A_0204);

        // round-robin with both requests held continuously
        f_req[0] = 1'b1; f_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_addr[0] = 32'h100; d_wr_en[0] = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk_acks(0, k == 2 || k == 8, k == 5 || k == 11, $sformatf("rr@%0d", k));
            if (k == 11) begin
                f_req[0] = 1'b0;
                d_req[0] = 1'b0;
            end
        end
        step();
        step();
        chk("rr f_rdata", f_rdata[0], 32'h0050_0093);
        chk("rr d_rdata", d_rdata[0], 32'h5A5A_0100);
        chk("rr idle", 32'(busy[0]), 32'd0);

        // fixed data priority: D first, F after D drops its request
        f_req[2] = 1'b1; f_addr[2] = 32'h204;
        d_req[2] = 1'b1; d_addr[2] = 32'h0; d_wr_en[2] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_acks(2, k == 9, k == 4, $sformatf("prio@%0d", k));
            if (k == 4) d_req[2] = 1'b0;
            if (k == 9) f_req[2] = 1'b0;
        end
        chk("prio f_rdata", f_rdata[2], 32'h5A5A_0204);
        chk("prio d_rdata", d_rdata[2], 32'h5A5A_0000);

        // fetch request dropped mid-access still completes
        f_req[1] = 1'b1; f_addr[1] = 32'h100;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) f_req[1] = 1'b0;
            chk_acks(1, k == 4, 1'b0, $sformatf("drop@%0d", k));
            chk($sformatf("drop@%0d busy", k), 32'(busy[1]), 32'(k <= 4));
        end
        chk("drop f_rdata", f_rdata[1], 32'h5A5A_0100);

        for (int g = 0; g < NI; g++) run_random(g, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
